// File: rtl/link_pkg.sv
// Shared definitions for the two-board boss state link.
// Both the transmit framer and the remote receive side import this package.
package link_pkg;

    localparam logic [7:0]  LINK_HEADER      = 8'hA5;
    localparam int unsigned LINK_FRAME_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        GAP
    } tx_state_t;

    function automatic logic [7:0] link_checksum(input logic [7:0] b0,
                                                 input logic [7:0] b1,
                                                 input logic [7:0] b2);
        return b0 ^ b1 ^ b2;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 UART byte serializer.
// A start request in the same cycle as done chains the next byte with no idle bit.
module uart_byte_tx #(
    parameter int unsigned BIT_CYCLES = 564
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;  // 0 = start, 1..8 = data, 9 = stop
    logic [7:0]    shift_q, shift_d;
    logic          busy_q, busy_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        busy_d  = busy_q;
        tx_d    = tx_q;
        done    = 1'b0;
        bit_end = busy_q && (cnt_q == CNT_LAST);

        if (busy_q) begin
            if (bit_end) begin
                cnt_d = '0;
                if (bit_q == 4'd9) begin
                    done = 1'b1;
                    if (start) begin
                        bit_d   = 4'd0;
                        shift_d = data;
                        tx_d    = 1'b0;
                    end else begin
                        busy_d = 1'b0;
                        tx_d   = 1'b1;
                    end
                end else begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd8) begin
                        tx_d = 1'b1;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (start) begin
            busy_d  = 1'b1;
            bit_d   = 4'd0;
            cnt_d   = '0;
            shift_d = data;
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            tx_q    <= tx_d;
        end
    end

    assign busy = busy_q;
    assign tx   = tx_q;

endmodule

// File: rtl/boss_state_tx.sv
// Boss state link transmitter: frames local HP and game status into a 4-byte
// packet and sends it whenever the values change, on game start, or on refresh.
module boss_state_tx
    import link_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 65_000_000,
    parameter int unsigned BAUD           = 115_200,
    parameter int unsigned REFRESH_CYCLES = 6_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] boss_hp,
    input  logic [1:0] game_active,
    input  logic       game_start,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       frame_sent
);

    localparam int unsigned BIT_CYCLES = CLK_HZ / BAUD;
    localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [1:0]    LAST_IDX     = 2'(LINK_FRAME_BYTES - 1);

    tx_state_t     state_q, state_d;
    logic          pending_q, pending_d;
    logic [6:0]    hp_q, hp_d;
    logic [1:0]    active_q, active_d;
    logic [6:0]    last_hp_q, last_hp_d;
    logic [1:0]    last_active_q, last_active_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    csum_q, csum_d;
    logic [RW-1:0] refresh_q, refresh_d;

    logic       busy;
    logic       refresh_hit;
    logic       send_req;
    logic [1:0] idx_nxt;
    logic [7:0] byte_nxt;
    logic       ser_start;
    logic [7:0] ser_data;
    logic       ser_busy;
    logic       ser_done;
    logic       ser_tx;

    assign busy        = (state_q != IDLE);
    assign refresh_hit = !busy && (refresh_q == REFRESH_LAST);
    assign send_req    = (boss_hp != last_hp_q) || (game_active != last_active_q) ||
                         game_start || refresh_hit;

    always_comb begin
        idx_nxt = idx_q + 2'd1;
        case (idx_nxt)
            2'd0:    byte_nxt = LINK_HEADER;
            2'd1:    byte_nxt = {1'b0, hp_q};
            2'd2:    byte_nxt = {6'b0, active_q};
            default: byte_nxt = csum_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q | send_req;
        hp_d          = hp_q;
        active_d      = active_q;
        last_hp_d     = last_hp_q;
        last_active_d = last_active_q;
        idx_d         = idx_q;
        csum_d        = csum_q;
        ser_start     = 1'b0;
        ser_data      = LINK_HEADER;

        case (state_q)
            IDLE: begin
                if (pending_q) state_d = LOAD;
            end
            LOAD: begin
                // The snapshot taken here already reflects any request seen this cycle.
                hp_d          = boss_hp;
                active_d      = game_active;
                last_hp_d     = boss_hp;
                last_active_d = game_active;
                pending_d     = 1'b0;
                csum_d        = link_checksum(LINK_HEADER, {1'b0, boss_hp}, {6'b0, game_active});
                idx_d         = 2'd0;
                ser_start     = 1'b1;
                ser_data      = LINK_HEADER;
                state_d       = SEND;
            end
            SEND: begin
                if (ser_busy && ser_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = GAP;
                    end else begin
                        idx_d     = idx_nxt;
                        ser_start = 1'b1;
                        ser_data  = byte_nxt;
                    end
                end
            end
            GAP: begin
                // Chain straight into the next frame when a request queued up mid-frame.
                state_d = pending_q ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        refresh_d = refresh_q;
        if (state_q == LOAD) begin
            refresh_d = '0;
        end else if (!busy) begin
            refresh_d = refresh_hit ? '0 : refresh_q + RW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pending_q     <= 1'b1;
            hp_q          <= '0;
            active_q      <= '0;
            last_hp_q     <= 7'h7F;
            last_active_q <= '0;
            idx_q         <= '0;
            csum_q        <= '0;
            refresh_q     <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            hp_q          <= hp_d;
            active_q      <= active_d;
            last_hp_q     <= last_hp_d;
            last_active_q <= last_active_d;
            idx_q         <= idx_d;
            csum_q        <= csum_d;
            refresh_q     <= refresh_d;
        end
    end

    uart_byte_tx #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_uart_byte_tx (
        .clk  (clk),
        .rst  (rst),
        .start(ser_start),
        .data (ser_data),
        .busy (ser_busy),
        .done (ser_done),
        .tx   (ser_tx)
    );

    assign uart_tx    = ser_tx;
    assign tx_busy    = busy;
    assign frame_sent = (state_q == GAP);

endmodule
